// File: rtl/alu_mc_pkg.sv
// Shared opcodes, flag indices and FSM states for the multi-cycle ALU.
package alu_mc_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_CPL  = 8'h03;
  localparam logic [7:0] OP_MUL  = 8'h04;
  localparam logic [7:0] OP_SHR  = 8'h05;
  localparam logic [7:0] OP_SHL  = 8'h06;
  localparam logic [7:0] OP_SAR  = 8'h07;
  localparam logic [7:0] OP_SAL  = 8'h08;
  localparam logic [7:0] OP_ROR  = 8'h09;
  localparam logic [7:0] OP_ROL  = 8'h0A;
  localparam logic [7:0] OP_NOT  = 8'h0B;
  localparam logic [7:0] OP_AND  = 8'h0C;
  localparam logic [7:0] OP_OR   = 8'h0D;
  localparam logic [7:0] OP_XOR  = 8'h0E;
  localparam logic [7:0] OP_NAND = 8'h0F;
  localparam logic [7:0] OP_NOR  = 8'h10;
  localparam logic [7:0] OP_XNOR = 8'h11;
  localparam logic [7:0] OP_DIV  = 8'h12;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and writeback.
interface alu_mc_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic [3:0]       st;
  logic             err;

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, q0, q1, st, err
  );

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, q0, q1, st, err
  );
endinterface

// File: rtl/alu_mc_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Divider path only exists when ALU_MC_DIV_EN is defined.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,   // 0 = multiply, 1 = divide
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,     // accumulator after this cycle's step
  output logic [WIDTH-1:0] lo      // shift register after this cycle's step
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, sreg, m;
  logic [WIDTH:0]   sum;

`ifdef ALU_MC_DIV_EN
  logic div_mode;

  always_ff @(posedge clk or posedge rst)
    if (rst)        div_mode <= 1'b0;
    else if (start) div_mode <= mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  always_comb begin
    sum = '0;
    hi  = acc;
    lo  = sreg;
`ifdef ALU_MC_DIV_EN
    if (div_mode) begin
      // Trial subtract; sum[WIDTH] is the borrow, meaning restore.
      sum = {acc, sreg[WIDTH-1]} - {1'b0, m};
      if (sum[WIDTH]) begin
        hi = {acc[WIDTH-2:0], sreg[WIDTH-1]};
        lo = {sreg[WIDTH-2:0], 1'b0};
      end else begin
        hi = sum[WIDTH-1:0];
        lo = {sreg[WIDTH-2:0], 1'b1};
      end
    end else
`endif
    begin
      sum = {1'b0, acc} + (sreg[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      hi  = sum[WIDTH:1];
      lo  = {sum[0], sreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
      acc  <= '0;
      sreg <= '0;
      m    <= '0;
    end else if (start) begin
      cnt  <= '0;
      busy <= 1'b1;
      acc  <= '0;
      sreg <= a;
      m    <= b;
    end else if (busy) begin
      cnt  <= cnt + 1'b1;
      acc  <= hi;
      sreg <= lo;
      busy <= (cnt != CW'(WIDTH-1));
    end

  assign done = busy && (cnt == CW'(WIDTH-1));

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle datapath plus iterative MUL
// (and DIV when ALU_MC_DIV_EN is defined), with registered two-word results.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus
);
  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_t           state, state_nxt;
  logic             accept, start, go_mul, go_div;
  logic             it_busy, it_done;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic [3:0]       it_st;

  logic [WIDTH-1:0] r_q0, r_q1;
  logic [3:0]       r_st;
  logic             r_err, use_nz, fc, fv;

  logic [WIDTH-1:0] q0, q1;
  logic [3:0]       st;
  logic             err, out_valid, in_ready;

  logic             sub;
  logic [WIDTH-1:0] ax, ay, yy;
  logic [WIDTH:0]   sum;
  logic [SW-1:0]    sh, r_idx, l_idx;
  logic [2*WIDTH-1:0] rr, rl;

  assign in_ready = (state == IDLE) && !it_busy && (!out_valid || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign start    = accept && (go_mul || go_div);

  // Shared adder and shift helpers; r_idx/l_idx are the last bit moved out.
  always_comb begin
    sub   = (bus.op != OP_ADD);
    ax    = (bus.op == OP_CPL) ? '0 : bus.a;
    ay    = (bus.op == OP_CPL) ? bus.a : bus.b;
    yy    = sub ? ~ay : ay;
    sum   = {1'b0, ax} + {1'b0, yy} + {{WIDTH{1'b0}}, sub};
    sh    = bus.b[SW-1:0];
    r_idx = sh - 1'b1;
    l_idx = ~sh + 1'b1;
    rr    = {bus.a, bus.a} >> sh;
    rl    = {bus.a, bus.a} << sh;
  end

  always_comb begin
    r_q0   = '0;
    r_q1   = '0;
    r_st   = '0;
    r_err  = 1'b0;
    go_mul = 1'b0;
    go_div = 1'b0;
    use_nz = 1'b1;
    fc     = 1'b0;
    fv     = 1'b0;
    case (bus.op)
      OP_NOP: begin
        r_q0   = bus.a;
        r_q1   = bus.b;
        use_nz = 1'b0;
      end
      OP_ADD, OP_SUB, OP_CPL: begin
        r_q0 = sum[WIDTH-1:0];
        fc   = sum[WIDTH];
        fv   = (ax[MSB] == yy[MSB]) && (sum[MSB] != ax[MSB]);
      end
      OP_MUL: begin
        go_mul = 1'b1;
        use_nz = 1'b0;
      end
      OP_SHR: begin
        r_q0 = bus.a >> sh;
        fc   = (|sh) && bus.a[r_idx];
      end
      OP_SHL, OP_SAL: begin
        r_q0 = bus.a << sh;
        fc   = (|sh) && bus.a[l_idx];
      end
      OP_SAR: begin
        r_q0 = $unsigned($signed(bus.a) >>> sh);
        fc   = (|sh) && bus.a[r_idx];
      end
      OP_ROR: begin
        r_q0 = rr[WIDTH-1:0];
        fc   = (|sh) && bus.a[r_idx];
      end
      OP_ROL: begin
        r_q0 = rl[2*WIDTH-1:WIDTH];
        fc   = (|sh) && bus.a[l_idx];
      end
      OP_NOT:  r_q0 = ~bus.a;
      OP_AND:  r_q0 = bus.a & bus.b;
      OP_OR:   r_q0 = bus.a | bus.b;
      OP_XOR:  r_q0 = bus.a ^ bus.b;
      OP_NAND: r_q0 = ~(bus.a & bus.b);
      OP_NOR:  r_q0 = ~(bus.a | bus.b);
      OP_XNOR: r_q0 = ~(bus.a ^ bus.b);
`ifdef ALU_MC_DIV_EN
      OP_DIV: begin
        use_nz = 1'b0;
        if (bus.b == '0) begin
          // Divide by zero resolves immediately, no iteration.
          r_q0  = '1;
          r_q1  = bus.a;
          fv    = 1'b1;
          r_err = 1'b1;
        end else begin
          go_div = 1'b1;
        end
      end
`endif
      default: begin
        r_err  = 1'b1;
        use_nz = 1'b0;
      end
    endcase
    r_st[FLAG_V] = fv;
    r_st[FLAG_C] = fc;
    r_st[FLAG_Z] = use_nz && (r_q0 == '0);
    r_st[FLAG_N] = use_nz && r_q0[MSB];
  end

  always_comb begin
    it_st = '0;
    if (state == MUL) begin
      it_st[FLAG_C] = |it_hi;
      it_st[FLAG_V] = |it_hi;
      it_st[FLAG_Z] = ~|{it_hi, it_lo};
    end else begin
      it_st[FLAG_Z] = ~|it_lo;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && go_mul)      state_nxt = MUL;
        else if (accept && go_div) state_nxt = DIV;
      end
      MUL, DIV: if (it_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers: a new load wins over a consume, so accept+consume has no bubble.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      q0        <= '0;
      q1        <= '0;
      st        <= '0;
      err       <= 1'b0;
    end else if (accept && !start) begin
      out_valid <= 1'b1;
      q0        <= r_q0;
      q1        <= r_q1;
      st        <= r_st;
      err       <= r_err;
    end else if (it_done) begin
      out_valid <= 1'b1;
      q0        <= it_lo;
      q1        <= it_hi;
      st        <= it_st;
      err       <= 1'b0;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (go_div),
    .a     (bus.a),
    .b     (bus.b),
    .busy  (it_busy),
    .done  (it_done),
    .hi    (it_hi),
    .lo    (it_lo)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.q0        = q0;
  assign bus.q1        = q1;
  assign bus.st        = st;
  assign bus.err       = err;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32); DIV vectors run when
// ALU_MC_DIV_EN is defined, otherwise opcode 0x12 is checked as invalid.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one op, expect it accepted at the next edge, then scramble inputs.
  task automatic send(input logic [7:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a  = x;
    bus.b  = y;
    #1 chk("in_ready_at_offer", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op = 8'hFF;
    bus.a  = $urandom;
    bus.b  = $urandom;
  endtask

  // Cycles (negedges) from accept until out_valid; notes any in_ready while waiting.
  task automatic wait_result(output int n, output bit rdy_seen);
    n = 0;
    rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.out_valid && bus.in_ready) rdy_seen = 1'b1;
    end while (!bus.out_valid && n < 100);
  endtask

  task automatic single(input string tag, input logic [7:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [3:0] est, input logic eerr);
    int n;
    bit rs;
    send(o, x, y);
    wait_result(n, rs);
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_q0"}, bus.q0, e0);
    chk({tag, "_q1"}, bus.q1, e1);
    chk({tag, "_st"}, bus.st, est);
    chk({tag, "_err"}, bus.err, eerr);
  endtask

  task automatic iter(input string tag, input logic [7:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] e0, input logic [31:0] e1,
                      input logic [3:0] est);
    int n;
    bit rs;
    send(o, x, y);
    wait_result(n, rs);
    chk({tag, "_lat"}, n, 33);
    chk({tag, "_busy_ready"}, rs, 0);
    chk({tag, "_q0"}, bus.q0, e0);
    chk({tag, "_q1"}, bus.q1, e1);
    chk({tag, "_st"}, bus.st, est);
    chk({tag, "_err"}, bus.err, 0);
  endtask

  initial begin
    logic [31:0] exp_q[4];
    int  got, idx;
    bit  fire, seen;

    bus.in_valid  = 1'b0;
    bus.op        = OP_NOP;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_q0", bus.q0, 0);
    chk("rst_q1", bus.q1, 0);
    chk("rst_st", bus.st, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    single("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 4'b1001, 0);
    single("sub_zero", OP_SUB, 32'd5, 32'd5, 32'h0, 0, 4'b0110, 0);
    single("cpl_one", OP_CPL, 32'd1, 32'h0, 32'hFFFF_FFFF, 0, 4'b1000, 0);
    single("ror1", OP_ROR, 32'h1, 32'h1, 32'h8000_0000, 0, 4'b1010, 0);
    single("shl0", OP_SHL, 32'h8000_0000, 32'h0, 32'h8000_0000, 0, 4'b1000, 0);
    single("shr4", OP_SHR, 32'h1F, 32'h4, 32'h1, 0, 4'b0010, 0);
    single("sar_mask", OP_SAR, 32'h8000_0000, 32'h21, 32'hC000_0000, 0, 4'b1000, 0);
    single("rol1", OP_ROL, 32'h8000_0000, 32'h1, 32'h1, 0, 4'b0010, 0);
    single("sal31", OP_SAL, 32'h3, 32'd31, 32'h8000_0000, 0, 4'b1010, 0);
    single("xor_z", OP_XOR, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0, 0, 4'b0100, 0);
    single("nand", OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 4'b0100, 0);
    single("nor", OP_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 4'b1000, 0);
    single("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 4'b0000, 0);
    single("nop", OP_NOP, 32'h12, 32'h34, 32'h12, 32'h34, 4'b0000, 0);
    single("bad_op", 8'h20, 32'h55, 32'h66, 32'h0, 32'h0, 4'b0000, 1);

    iter("mul_big", OP_MUL, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h1, 4'b0011);
    iter("mul_sh", OP_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'h1, 4'b0011);
    iter("mul_zero", OP_MUL, 32'h0, 32'h5, 32'h0, 32'h0, 4'b0100);

`ifdef ALU_MC_DIV_EN
    iter("div", OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000);
    single("div0", OP_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 4'b0001, 1);
`else
    single("div_off", OP_DIV, 32'd100, 32'd7, 32'h0, 32'h0, 4'b0000, 1);
`endif

    // Back-to-back ADDs with a 3-cycle writeback stall.
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    exp_q = '{32'd11, 32'd21, 32'd31, 32'd41};
    got = 0;
    idx = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 2 && cyc < 5);
      bus.in_valid  = (idx < 4);
      bus.op        = OP_ADD;
      bus.a         = 32'(10 * (idx + 1));
      bus.b         = 32'd1;
      #1;
      if (bus.out_valid && !bus.out_ready) chk("b2b_stall_q0", bus.q0, exp_q[got]);
      if (bus.out_valid && bus.out_ready) begin
        chk("b2b_q0", bus.q0, exp_q[got]);
        got++;
      end
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (fire) idx++;
    end
    bus.in_valid = 1'b0;
    chk("b2b_count", got, 4);
    @(negedge clk);
    chk("b2b_no_dup", bus.out_valid, 0);

    // Reset 10 cycles into a MUL aborts it with no result.
    send(OP_MUL, 32'h1234, 32'h5678);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_q0", bus.q0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, handshaked successor of the combinational 32-bit ALU: WIDTH-bit operands, registered results, and iterative shift-add multiply (plus optional restoring divide) instead of a combinational array multiplier. It sits between the operand-fetch stage and writeback. It accepts one operation per valid/ready transfer and presents a two-word result with status flags until writeback consumes it.

## Interface
- WIDTH, 32: operand/result width; power of two, 8..64.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- op  in  8  opcode; codes in the package.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- q0, q1  out  WIDTH  result words (q1 = high/remainder/second word).
- st  out  4  flags: bit0 V, bit1 C, bit2 Z, bit3 N.
- err  out  1  opcode was invalid, or divide by zero.

## Operation
- Opcodes: 00 NOP (q0=a, q1=b, st=0); 01 ADD; 02 SUB; 03 CPL (0−a); 04 MUL; 05 SHR; 06 SHL; 07 SAR; 08 SAL; 09 ROR; 0A ROL; 0B NOT a; 0C AND; 0D OR; 0E XOR; 0F NAND; 10 NOR; 11 XNOR; 12 DIV (only when configured).
- Any other code: q0=q1=0, st=0, err=1. Latency is 1.
- ADD/SUB/CPL: computed as a + (sub ? ~b : b) + sub.
  - C = carry out of the MSB.
  - V = true signed overflow: operands of equal effective sign with a result of the other sign.
  - N = q0 MSB. Z = (q0==0). q1 = 0.
- Shifts: amount = b[$clog2(WIDTH)-1:0].
  - C = last bit shifted or rotated out; C=0 when amount is 0. q0=a when amount is 0.
  - SAL is identical to SHL. SAR replicates the sign bit.
  - V=0. N and Z taken from q0.
- Bitwise ops: Z from q0, N = q0 MSB, C=V=0.
- MUL: unsigned. {q1,q0} = a*b.
  - C = V = |q1. Z = ({q1,q0}==0). N = 0.
- DIV: unsigned restoring division. q0 = quotient, q1 = remainder. Z = (q0==0). N = C = V = 0.
- Divide by zero: q0 = all ones, q1 = a, V=1, err=1, latency 1 (no iteration).
- State machine:
  - IDLE: accepts an op. Single-cycle ops load the result registers directly. MUL enters MUL; a DIV with a nonzero divisor enters DIV.
  - MUL / DIV: iteration counter runs WIDTH cycles, one partial product or one quotient bit per cycle. After the final step the result loads and the FSM returns to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- in_ready is low throughout MUL and DIV.
- Operands are captured on accept. Later changes to a/b/op have no effect.

## Timing
- Reset values: state IDLE, out_valid=0, q0=q1=0, st=0, err=0, counter 0.
- Single-cycle ops: result and out_valid appear in the cycle after the accept.
  - Throughput is 1 per cycle while out_ready is held high.
- MUL and DIV: out_valid rises WIDTH+1 cycles after the accept.
- out_valid stays high and q0/q1/st/err stay stable until out_ready is sampled high.
- Simultaneous consume and accept of a single-cycle op: the new result replaces the old one with no bubble.
- Consume while an iteration is in progress: out_valid drops in the next cycle. The pending iterative result loads when it completes.
- Reset asserted mid-iteration: the operation is aborted and all outputs return to reset values immediately (asynchronously). No result is produced.
- Iteration counter width: $clog2(WIDTH)+1. It must not wrap before reaching WIDTH.

## Configuration
- ALU_MC_DIV_EN defined: opcode 12 performs DIV as specified, adding the DIV state and the remainder datapath.
- ALU_MC_DIV_EN undefined: opcode 12 is invalid (zero result, err=1, latency 1). No divider logic is present.

## Structure
- Package alu_mc_pkg holds:
  - the opcode constants (8-bit, names OP_NOP … OP_DIV);
  - the flag bit-index constants (FLAG_V=0, FLAG_C=1, FLAG_Z=2, FLAG_N=3);
  - the FSM state enum (IDLE, MUL, DIV).
- One sub-module, alu_mc_iter, holds the shared accumulator, shift register and iteration counter for MUL and DIV.
  - Interface: start, mode, a, b, busy, done, hi, lo.
  - The top level keeps the single-cycle datapath, the handshake and the result registers.

## Test plan
- Reset, then ADD a=0x7FFFFFFF, b=1 with out_ready=1 → next cycle q0=0x80000000, st=V|N (4'b1001), C=0, err=0.
- SUB a=5, b=5 → q0=0, st=Z|C (4'b0110). CPL a=1 → q0=0xFFFFFFFF, N=1.
- MUL a=0xFFFFFFFF, b=2 → in_ready low for 32 cycles; out_valid on cycle 33 after the accept; q1=1, q0=0xFFFFFFFE, C=V=1.
- Back-to-back: 4 ADDs with out_ready stalled for 3 cycles → exactly 4 results in order, none lost or duplicated; q0 stable while stalled.
- ROR a=0x00000001, b=1 → q0=0x80000000, C=1. SHL a=0x80000000, b=0 → q0=0x80000000, C=0.
- With ALU_MC_DIV_EN: DIV 100/7 → q0=14, q1=2 after 33 cycles; DIV a=9, b=0 → next cycle q0=0xFFFFFFFF, q1=9, err=1.
- Reset asserted 10 cycles into a MUL → out_valid stays 0 and in_ready rises immediately after release.
- Opcode 0x20 → err=1, q0=q1=0.
